serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor: computes a − b one bit per clock, LSB first, using a single full-adder cell plus a registered carry (a + ~b + 1).
- Counterpart to the team's combinational ripple-carry adders. It is the inverse operation, built sequentially with a start/done handshake.
- Sits as a datapath slave under a controller that loads operands and waits for done.

---
 rtl/serial_subtractor_if.sv | 22 ++
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a sequencing controller and serial_subtractor.
// Carries ovf only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b computed LSB first as a + ~b + 1 with one full-adder cell.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVERFLOW_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one result bit produced per clock, WIDTH clocks total
// DONE  | one-cycle done pulse, diff/borrow freshly updated
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic sum_bit;
    logic carry_out;

    always_comb begin
        sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        carry_out = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        count_d  = count_q;
        carry_d  = carry_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = ~bus.b;
                    res_sr_d = '0;
                    count_d  = '0;
                    carry_d  = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d  = bus.a[WIDTH-1];
                    b_msb_d  = bus.b[WIDTH-1];
`endif
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = {sum_bit, res_sr_q[WIDTH-1:1]};
                carry_d  = carry_out;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    // the last sum bit lands in the result MSB on this same edge
                    diff_d   = {sum_bit, res_sr_q[WIDTH-1:1]};
                    borrow_d = ~carry_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (sum_bit != a_msb_q);
`endif
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            count_q  <= '0;
            carry_q  <= 1'b1;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy   = (state_q == SHIFT);
    assign bus.done   = (state_q == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4); checks ovf too when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   fails;
    logic [W-1:0] prev_diff;
    logic         prev_borrow;
    logic         prev_ovf;
    logic         ovf_obs;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef SERIAL_SUB_OVERFLOW_EN
    assign ovf_obs = bus.ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    // One operation: accept, 4 SHIFT cycles, one DONE cycle, then idle with result held.
    task automatic do_op(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                         input logic [W-1:0] exp_d, input logic exp_b, input logic exp_o);
        @(negedge clk);
        bus.start = 1'b1; bus.a = a_in; bus.b = b_in;
        @(negedge clk);
        bus.start = 1'b0; bus.a = ~a_in; bus.b = ~b_in;
        for (int i = 1; i <= W; i++) begin
            tests_run++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                fails++;
                $display("FAIL op_shift a=%0h b=%0h cyc=%0d: busy=%b done=%b, required busy=1 done=0", a_in, b_in, i, bus.busy, bus.done);
            end
            tests_run++;
            if (bus.diff !== prev_diff || bus.borrow !== prev_borrow) begin
                fails++;
                $display("FAIL op_hold a=%0h b=%0h cyc=%0d: diff=%h borrow=%b, required diff=%h borrow=%b", a_in, b_in, i, bus.diff, bus.borrow, prev_diff, prev_borrow);
            end
            @(negedge clk);
        end
        tests_run++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL op_done a=%0h b=%0h: done=%b busy=%b, required done=1 busy=0", a_in, b_in, bus.done, bus.busy);
        end
        tests_run++;
        if (bus.diff !== exp_d || bus.borrow !== exp_b) begin
            fails++;
            $display("FAIL op_result a=%0h b=%0h: diff=%h borrow=%b, required diff=%h borrow=%b", a_in, b_in, bus.diff, bus.borrow, exp_d, exp_b);
        end
`ifdef SERIAL_SUB_OVERFLOW_EN
        tests_run++;
        if (ovf_obs !== exp_o) begin
            fails++;
            $display("FAIL op_ovf a=%0h b=%0h: ovf=%b, required %b", a_in, b_in, ovf_obs, exp_o);
        end
`endif
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.diff !== exp_d || bus.borrow !== exp_b) begin
            fails++;
            $display("FAIL op_after a=%0h b=%0h: done=%b busy=%b diff=%h borrow=%b, required 0 0 %h %b", a_in, b_in, bus.done, bus.busy, bus.diff, bus.borrow, exp_d, exp_b);
        end
        prev_diff = exp_d; prev_borrow = exp_b; prev_ovf = exp_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 4'h0 || bus.borrow !== 1'b0 || ovf_obs !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d: busy=%b done=%b diff=%h borrow=%b ovf=%b, required all zero", i, bus.busy, bus.done, bus.diff, bus.borrow, ovf_obs);
            end
        end
        prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0;
    endtask

    task automatic test_subtract();
        logic [W-1:0] va [7];
        logic [W-1:0] vb [7];
        logic [W-1:0] vd [7];
        logic         vbr [7];
        logic         vo [7];
        va = '{4'h9, 4'h3, 4'h0, 4'h0, 4'h8, 4'h7, 4'h5};
        vb = '{4'h3, 4'h9, 4'h1, 4'h0, 4'h1, 4'hF, 4'h3};
        vd = '{4'h6, 4'hA, 4'hF, 4'h0, 4'h7, 4'h8, 4'h2};
        vbr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vo = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++)
            do_op(va[i], vb[i], vd[i], vbr[i], vo[i]);
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'h9; bus.b = 4'h3;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.start = 1'b0;
            if (cyc == 2) begin bus.start = 1'b1; bus.a = 4'h1; bus.b = 4'h1; end
            if (cyc == 3) bus.start = 1'b0;
            if (bus.done === 1'b1) done_cnt++;
            tests_run++;
            if (bus.busy !== ((cyc >= 1 && cyc <= 4) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL ignore_busy cyc=%0d: busy=%b, required %b", cyc, bus.busy, (cyc <= 4));
            end
            if (cyc == 5) begin
                tests_run++;
                if (bus.diff !== 4'h6 || bus.borrow !== 1'b0) begin
                    fails++;
                    $display("FAIL ignore_result: diff=%h borrow=%b, required diff=6 borrow=0", bus.diff, bus.borrow);
                end
            end
        end
        tests_run++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL ignore_done_count: %0d done pulses, required 1", done_cnt);
        end
        prev_diff = 4'h6; prev_borrow = 1'b0; prev_ovf = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic exp_busy, exp_done;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'h6; bus.b = 4'h1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            if (cyc == 4) begin bus.a = 4'h2; bus.b = 4'h7; end
            exp_busy = (cyc >= 1 && cyc <= 4) || (cyc >= 7 && cyc <= 10);
            exp_done = (cyc == 5) || (cyc == 11);
            tests_run++;
            if (bus.busy !== exp_busy || bus.done !== exp_done) begin
                fails++;
                $display("FAIL b2b_ctrl cyc=%0d: busy=%b done=%b, required busy=%b done=%b", cyc, bus.busy, bus.done, exp_busy, exp_done);
            end
            if (cyc == 5) begin
                tests_run++;
                if (bus.diff !== 4'h5 || bus.borrow !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_first: diff=%h borrow=%b, required diff=5 borrow=0", bus.diff, bus.borrow);
                end
            end
            if (cyc == 11) begin
                tests_run++;
                if (bus.diff !== 4'hB || bus.borrow !== 1'b1 || ovf_obs !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_second: diff=%h borrow=%b ovf=%b, required diff=b borrow=1 ovf=0", bus.diff, bus.borrow, ovf_obs);
                end
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        prev_diff = 4'hB; prev_borrow = 1'b1; prev_ovf = 1'b0;
    endtask

    task automatic test_reset_abort();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'h5; bus.b = 4'h2;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 4'h0 || bus.borrow !== 1'b0 || ovf_obs !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: busy=%b done=%b diff=%h borrow=%b ovf=%b, required all zero", bus.busy, bus.done, bus.diff, bus.borrow, ovf_obs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_cnt++;
        end
        tests_run++;
        if (done_cnt != 0) begin
            fails++;
            $display("FAIL abort_quiet: %0d cycles with busy/done high after abort, required 0", done_cnt);
        end
        prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0;
        do_op(4'h5, 4'h2, 4'h3, 1'b0, 1'b0);
    endtask

    initial begin
        tests_run = 0;
        fails = 0;
        prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0;
        test_reset();
        test_subtract();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
